tsmp_decap_dispatch_mc: RTL and testbench

- Parametrised, multi-channel successor of the TSMP decapsulate/dispatch stage in the HCP path.
- Strips a configurable-length TSMP header from a 9-bit byte stream and steers the payload to one of NUM_CH consumers (CSM, MUX, NMAC config, ...) by subtype, using a runtime-programmable subtype table.
- Patches PTP frames with a local transmit timer and synchronised global time at parametrised offsets.
- Drops runt and unmatched frames and counts them.

---
 rtl/tsmp_decap_dispatch_mc.sv | 248 ++++++++++++++++++++++++
 tb/tb_tsmp_decap_dispatch_mc.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tsmp_decap_dispatch_mc.sv
// TSMP decapsulate/dispatch stage, multi-channel variant.
// Strips the header, steers payload by subtype, patches PTP time fields.
module tsmp_decap_dispatch_mc #(
    parameter int          NUM_CH      = 4,
    parameter int          HDR_LEN     = 16,
    parameter int          SUBTYPE_OFS = 14,
    parameter int          DESC_W      = 35,
    parameter logic [15:0] PTP_DESC    = 16'hff01,
    parameter logic [7:0]  PTP_SUBTYPE = 8'h05,
    parameter int          TT_OFS      = 3,
    parameter int          GT_OFS      = 52,
    parameter int          TIMER_MAX   = 499999,
    parameter int          TT_W        = 19,
    parameter int          MAC_CH      = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_timer_rst,
    input  logic [47:0]           iv_syned_global_time,
    input  logic [8:0]            iv_data,
    input  logic [DESC_W-1:0]     iv_descriptor,
    input  logic                  i_data_wr,
    input  logic [NUM_CH*8-1:0]   iv_ch_subtype,
    input  logic [NUM_CH-1:0]     iv_ch_en,
    output logic [8:0]            ov_data,
    output logic [NUM_CH-1:0]     ov_data_wr,
    output logic [47:0]           ov_dmac,
    output logic [47:0]           ov_smac,
    output logic                  o_mac_valid,
    output logic [15:0]           ov_runt_cnt,
    output logic [15:0]           ov_nomatch_cnt
);

    localparam int HC_W = $clog2(HDR_LEN + 1);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TT_HI = (TT_W > 16) ? TT_W - 16 : 0;
    localparam logic [7:0] TT_MASK = 8'hFF << TT_HI;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_FWD, S_DROP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [HC_W-1:0]   r_hcnt;
    logic [47:0]       r_dmac;
    logic [47:0]       r_smac;
    logic [7:0]        r_subtype;
    logic              r_match;
    logic [CH_W-1:0]   r_ch;
    logic [TT_W-1:0]   r_timer;
    logic [TT_W-1:0]   r_tt;
    logic [47:0]       r_gt;
    logic              r_ptp;
    logic [15:0]       r_pcnt;
    logic              r_pwrap;

    logic              w_hit;
    logic [CH_W-1:0]   w_hit_ch;
    logic              w_at_sub;
    logic              w_match;
    logic [CH_W-1:0]   w_ch;
    logic              w_start;
    logic              w_runt;
    logic              w_enter_fwd;
    logic              w_enter_drop;
    logic              w_first;
    logic              w_ptp_cand;
    logic              w_ptp;
    logic [23:0]       w_tt24;
    logic [47:0]       w_gt;
    logic [2:0]        w_gidx;
    logic [2:0]        w_gsel;
    logic [8:0]        w_out;
    logic              w_unused;

    assign w_unused = ^iv_descriptor;

    // Subtype table lookup: lowest enabled channel wins
    always_comb begin
        w_hit    = 1'b0;
        w_hit_ch = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (iv_ch_en[k] && (iv_ch_subtype[8*k +: 8] == iv_data[7:0])) begin
                w_hit    = 1'b1;
                w_hit_ch = CH_W'(k);
            end
        end
    end

    assign w_at_sub = (r_hcnt == HC_W'(SUBTYPE_OFS));
    assign w_match  = w_at_sub ? w_hit : r_match;
    assign w_ch     = w_at_sub ? w_hit_ch : r_ch;

    // Frame FSM next-state and transition strobes
    always_comb begin
        w_next       = r_state;
        w_start      = 1'b0;
        w_runt       = 1'b0;
        w_enter_fwd  = 1'b0;
        w_enter_drop = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_data_wr && iv_data[8]) begin
                    w_next  = S_HDR;
                    w_start = 1'b1;
                end
            end
            S_HDR: begin
                if (i_data_wr) begin
                    if (iv_data[8]) begin
                        w_next = S_IDLE;
                        w_runt = 1'b1;
                    end else if (r_hcnt == HC_W'(HDR_LEN - 1)) begin
                        if (w_match) begin
                            w_next      = S_FWD;
                            w_enter_fwd = 1'b1;
                        end else begin
                            w_next       = S_DROP;
                            w_enter_drop = 1'b1;
                        end
                    end
                end
            end
            S_FWD, S_DROP: begin
                if (i_data_wr && iv_data[8]) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Header capture: MACs, subtype and channel decision
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hcnt    <= '0;
            r_dmac    <= '0;
            r_smac    <= '0;
            r_subtype <= '0;
            r_match   <= 1'b0;
            r_ch      <= '0;
        end else if (w_start) begin
            r_hcnt  <= HC_W'(1);
            r_dmac  <= {r_dmac[39:0], iv_data[7:0]};
            r_match <= 1'b0;
        end else if (r_state == S_HDR && i_data_wr) begin
            r_hcnt <= r_hcnt + 1'b1;
            if (r_hcnt < HC_W'(6))
                r_dmac <= {r_dmac[39:0], iv_data[7:0]};
            else if (r_hcnt < HC_W'(12))
                r_smac <= {r_smac[39:0], iv_data[7:0]};
            if (w_at_sub) begin
                r_subtype <= iv_data[7:0];
                r_match   <= w_hit;
                r_ch      <= w_hit_ch;
            end
        end
    end

    // Free-running transmit timer; synchronous clear wins over wrap
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                           r_timer <= '0;
        else if (i_timer_rst)                   r_timer <= '0;
        else if (r_timer == TT_W'(TIMER_MAX))   r_timer <= '0;
        else                                    r_timer <= r_timer + 1'b1;
    end

    assign w_first    = (r_pcnt == 16'd0) && !r_pwrap;
    assign w_ptp_cand = (r_subtype == PTP_SUBTYPE) &&
                        (iv_descriptor[15:0] == PTP_DESC);
    assign w_ptp      = !r_pwrap && (w_first ? w_ptp_cand : r_ptp);
    assign w_tt24     = 24'(w_first ? r_timer : r_tt);
    assign w_gt       = w_first ? iv_syned_global_time : r_gt;
    assign w_gidx     = 3'(r_pcnt - 16'(GT_OFS));
    assign w_gsel     = 3'd5 - w_gidx;

    // Payload byte with boundary flag and PTP field patching
    always_comb begin
        w_out = {iv_data[8] | w_first, iv_data[7:0]};
        unique case (1'b1)
            w_ptp && (r_pcnt == 16'(TT_OFS)):
                w_out[7:0] = (iv_data[7:0] & TT_MASK) | w_tt24[23:16];
            w_ptp && (r_pcnt == 16'(TT_OFS + 1)):
                w_out[7:0] = w_tt24[15:8];
            w_ptp && (r_pcnt == 16'(TT_OFS + 2)):
                w_out[7:0] = w_tt24[7:0];
            w_ptp && (r_pcnt >= 16'(GT_OFS)) && (r_pcnt < 16'(GT_OFS + 6)):
                w_out[7:0] = w_gt[{w_gsel, 3'b000} +: 8];
            default: ;
        endcase
    end

    // Payload forwarding, PTP latch and MAC publication
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ov_data     <= '0;
            ov_data_wr  <= '0;
            ov_dmac     <= '0;
            ov_smac     <= '0;
            o_mac_valid <= 1'b0;
            r_pcnt      <= '0;
            r_pwrap     <= 1'b0;
            r_ptp       <= 1'b0;
            r_tt        <= '0;
            r_gt        <= '0;
        end else begin
            ov_data_wr  <= '0;
            o_mac_valid <= 1'b0;
            if (w_enter_fwd) begin
                r_pcnt  <= '0;
                r_pwrap <= 1'b0;
                if (w_ch == CH_W'(MAC_CH)) begin
                    ov_dmac     <= r_dmac;
                    ov_smac     <= r_smac;
                    o_mac_valid <= 1'b1;
                end
            end
            if (r_state == S_FWD && i_data_wr) begin
                ov_data    <= w_out;
                ov_data_wr <= NUM_CH'(1) << r_ch;
                r_pcnt     <= r_pcnt + 16'd1;
                if (r_pcnt == 16'hFFFF) r_pwrap <= 1'b1;
                if (w_first) begin
                    r_ptp <= w_ptp_cand;
                    r_tt  <= r_timer;
                    r_gt  <= iv_syned_global_time;
                end
            end
        end
    end

    // Saturating drop counters
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ov_runt_cnt    <= '0;
            ov_nomatch_cnt <= '0;
        end else begin
            if (w_runt && ov_runt_cnt != 16'hFFFF)
                ov_runt_cnt <= ov_runt_cnt + 16'd1;
            if (w_enter_drop && ov_nomatch_cnt != 16'hFFFF)
                ov_nomatch_cnt <= ov_nomatch_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_tsmp_decap_dispatch_mc.sv
// Bench for tsmp_decap_dispatch_mc: directed and random frames
// checked against a frame-level reference model.
module tb_tsmp_decap_dispatch_mc;

    localparam int NCH  = 4;
    localparam int HDR  = 16;
    localparam int TMAX = 999;
    localparam int MACC = 1;
    localparam int TTO  = 3;
    localparam int GTO  = 52;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_timer_rst = 1'b0;
    logic [47:0]  gtime = '0;
    logic [8:0]   iv_data = '0;
    logic [34:0]  desc = '0;
    logic         wr = 1'b0;
    logic [31:0]  tab = '0;
    logic [3:0]   en = '0;
    logic [8:0]   ov_data;
    logic [3:0]   ov_data_wr;
    logic [47:0]  ov_dmac;
    logic [47:0]  ov_smac;
    logic         o_mac_valid;
    logic [15:0]  ov_runt_cnt;
    logic [15:0]  ov_nomatch_cnt;

    tsmp_decap_dispatch_mc #(.TIMER_MAX(TMAX), .MAC_CH(MACC)) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_timer_rst(i_timer_rst),
        .iv_syned_global_time(gtime),
        .iv_data(iv_data),
        .iv_descriptor(desc),
        .i_data_wr(wr),
        .iv_ch_subtype(tab),
        .iv_ch_en(en),
        .ov_data(ov_data),
        .ov_data_wr(ov_data_wr),
        .ov_dmac(ov_dmac),
        .ov_smac(ov_smac),
        .o_mac_valid(o_mac_valid),
        .ov_runt_cnt(ov_runt_cnt),
        .ov_nomatch_cnt(ov_nomatch_cnt)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int mac_cnt = 0;
    int m_timer = 0;
    int exp_runt = 0;
    int exp_nm = 0;
    int exp_mac = 0;
    logic [47:0] exp_dm = '0;
    logic [47:0] exp_sm = '0;
    logic [44:0] got[$];
    logic [44:0] expq[$];

    always @(posedge i_clk) cyc <= cyc + 1;

    // Reference timer: counts modulo TMAX+1, cleared by i_timer_rst
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)         m_timer <= 0;
        else if (i_timer_rst) m_timer <= 0;
        else                  m_timer <= (m_timer + 1) % (TMAX + 1);
    end

    // Output monitor
    always @(negedge i_clk) begin
        if (ov_data_wr != 4'b0)
            got.push_back({32'(cyc), ov_data_wr, ov_data});
        if (o_mac_valid) mac_cnt <= mac_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] o,
                       input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic logic [7:0] pbyte(input int i, input logic [7:0] b,
                                         input bit ptp, input int tt,
                                         input logic [47:0] gt);
        if (!ptp) return b;
        if (i == TTO) return (b & 8'hF8) | 8'(tt >> 16);
        if (i == TTO + 1) return 8'(tt >> 8);
        if (i == TTO + 2) return 8'(tt);
        if (i >= GTO && i < GTO + 6) return 8'(gt >> (8 * (GTO + 5 - i)));
        return b;
    endfunction

    task automatic send_frame(input logic [47:0] dm, input logic [47:0] sm,
                              input logic [7:0] st, input int n,
                              input logic [15:0] d, input int gap);
        logic [7:0] fb[$];
        logic [7:0] b;
        logic [47:0] gt;
        int ch;
        int tt;
        bit ptp;
        for (int i = 0; i < n; i++) begin
            if (i < 6)       b = dm[8*(5-i) +: 8];
            else if (i < 12) b = sm[8*(11-i) +: 8];
            else if (i == 12) b = 8'h88;
            else if (i == 13) b = 8'hF7;
            else if (i == 14) b = st;
            else             b = 8'($urandom);
            fb.push_back(b);
        end
        ch = -1;
        for (int k = 0; k < NCH; k++)
            if (ch < 0 && en[k] && tab[8*k +: 8] == st) ch = k;
        ptp = 1'b0;
        tt = 0;
        gt = '0;
        if (n <= HDR) exp_runt++;
        else if (ch < 0) exp_nm++;
        else if (ch == MACC) begin
            exp_mac++;
            exp_dm = dm;
            exp_sm = sm;
        end
        desc = {19'h0, d};
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < 4 && $urandom_range(0, 99) < gap; g++) begin
                wr = 1'b0;
                iv_data = 9'($urandom);
                @(posedge i_clk); #1;
            end
            iv_data = {(i == 0 || i == n - 1), fb[i]};
            wr = 1'b1;
            if (n > HDR && ch >= 0 && i >= HDR) begin
                if (i == HDR) begin
                    ptp = (st == 8'h05 && d == 16'hff01);
                    tt = m_timer;
                    gt = gtime;
                end
                expq.push_back({32'(cyc + 1), 4'(1 << ch),
                                (i == HDR || i == n - 1),
                                pbyte(i - HDR, fb[i], ptp, tt, gt)});
            end
            @(posedge i_clk); #1;
        end
        wr = 1'b0;
    endtask

    task automatic drain_check(input string tag);
        repeat (3) @(posedge i_clk);
        #1;
        chk({tag, "_nbytes"}, got.size(), expq.size());
        for (int i = 0; i < expq.size(); i++)
            if (i < got.size()) chk({tag, "_byte"}, got[i], expq[i]);
        chk({tag, "_runt"}, ov_runt_cnt, exp_runt);
        chk({tag, "_nomatch"}, ov_nomatch_cnt, exp_nm);
        chk({tag, "_macpulse"}, mac_cnt, exp_mac);
        chk({tag, "_dmac"}, ov_dmac, exp_dm);
        chk({tag, "_smac"}, ov_smac, exp_sm);
        got.delete();
        expq.delete();
    endtask

    initial begin
        logic [7:0] sts[3];
        logic [15:0] dsel;
        sts[0] = 8'h02;
        sts[1] = 8'h05;
        sts[2] = 8'h07;

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_data", ov_data, 0);
        chk("rst_wr", ov_data_wr, 0);
        chk("rst_dmac", ov_dmac, 0);
        chk("rst_smac", ov_smac, 0);
        chk("rst_macv", o_mac_valid, 0);
        chk("rst_runt", ov_runt_cnt, 0);
        chk("rst_nm", ov_nomatch_cnt, 0);
        chk("rst_timer", dut.r_timer, 0);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // ch3..ch0 subtypes: 02, 05, 02, 05
        tab = {8'h02, 8'h05, 8'h02, 8'h05};
        en = 4'b1111;

        send_frame(48'h010203040506, 48'h111213141516, 8'h02, 20, 16'h0, 0);
        drain_check("basic_ch1");

        gtime = 48'h0011_2233_4455;
        send_frame(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 8'h05, 80, 16'hff01, 0);
        drain_check("ptp");
        send_frame(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 8'h05, 80, 16'hff02, 0);
        drain_check("ptp_baddesc");

        send_frame(48'h1, 48'h2, 8'h07, 30, 16'h0, 0);
        send_frame(48'hC0C1C2C3C4C5, 48'hD0D1D2D3D4D5, 8'h02, 24, 16'h0, 0);
        drain_check("nomatch_b2b");

        send_frame(48'h5, 48'h6, 8'h02, 10, 16'h0, 0);
        drain_check("runt10");
        chk("runt10_idle", dut.r_state, 0);
        send_frame(48'h5, 48'h6, 8'h02, HDR, 16'h0, 0);
        drain_check("runt16");
        send_frame(48'h7, 48'h8, 8'h02, HDR + 1, 16'h0, 0);
        drain_check("single_payload");

        en = 4'b1101;
        send_frame(48'h9, 48'hA, 8'h02, 22, 16'h0, 0);
        drain_check("ch1_off");
        en = 4'b1111;

        send_frame(48'hE0E1E2E3E4E5, 48'hF0F1F2F3F4F5, 8'h02, 40, 16'h0, 30);
        drain_check("gaps");

        for (int r = 0; r < 6; r++) begin
            en = 4'($urandom);
            gtime = {16'($urandom), 32'($urandom)};
            dsel = ($urandom_range(0, 1) == 0) ? 16'hff01 : 16'hff02;
            send_frame({16'($urandom), 32'($urandom)},
                       {16'($urandom), 32'($urandom)},
                       sts[$urandom_range(0, 2)],
                       $urandom_range(17, 90), dsel, 30);
            drain_check("rand");
        end
        en = 4'b1111;

        for (int i = 0; i < 5; i++) begin
            iv_data = {1'b0, 8'($urandom)};
            wr = 1'b1;
            @(posedge i_clk); #1;
        end
        wr = 1'b0;
        drain_check("idle_junk");

        // Timer wrap and synchronous clear priority
        for (int i = 0; i < 1100 && m_timer != TMAX; i++) begin
            @(posedge i_clk); #1;
        end
        chk("tmr_at_max", dut.r_timer, TMAX);
        i_timer_rst = 1'b1;
        @(posedge i_clk); #1;
        i_timer_rst = 1'b0;
        chk("tmr_clr_at_max", dut.r_timer, 0);
        repeat (5) @(posedge i_clk);
        #1;
        chk("tmr_count", dut.r_timer, 5);
        for (int i = 0; i < 1100 && m_timer != TMAX; i++) begin
            @(posedge i_clk); #1;
        end
        @(posedge i_clk); #1;
        chk("tmr_wrap", dut.r_timer, 0);

        // Reset asserted mid-frame
        for (int i = 0; i < 8; i++) begin
            iv_data = {(i == 0), 8'(8'hA0 + i)};
            wr = 1'b1;
            @(posedge i_clk); #1;
        end
        i_rst_n = 1'b0;
        #1;
        wr = 1'b0;
        chk("mrst_data", ov_data, 0);
        chk("mrst_wr", ov_data_wr, 0);
        chk("mrst_dmac", ov_dmac, 0);
        chk("mrst_smac", ov_smac, 0);
        chk("mrst_runt", ov_runt_cnt, 0);
        chk("mrst_nm", ov_nomatch_cnt, 0);
        exp_runt = 0;
        exp_nm = 0;
        exp_dm = '0;
        exp_sm = '0;
        got.delete();
        expq.delete();
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        send_frame(48'h010203040506, 48'h111213141516, 8'h02, 20, 16'h0, 0);
        drain_check("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
